fifo_pack: RTL and testbench

FIFO_PACK -- requirements
Module: fifo_pack

---
 rtl/fifo_pack.sv | 132 +++++++++++++
 tb/tb_fifo_pack.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack.sv
// fifo_pack: packs RATIO narrow input beats into one wide word and queues the
// words in a DEPTH-entry show-ahead FIFO. A flush commits a partial word with
// zero-padded upper lanes, and out_lanes reports how many lanes are valid.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   data_in          input beat (IN_W bits)
//   input_valid      beat present on data_in
//   input_enable     block can accept a beat this cycle
//   flush            level request to commit the partial word
//   data_out         head word, first-received beat in lane 0
//   out_lanes        number of valid lanes in data_out
//   output_valid     head word present
//   output_enable    consumer takes the head word
//   count            stored words (0..DEPTH)
//   full, empty      count==DEPTH / count==0
module fifo_pack #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RATIO = 2,
  parameter int unsigned DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [IN_W-1:0]               data_in,
  input  logic                          input_valid,
  output logic                          input_enable,
  input  logic                          flush,
  output logic [IN_W*RATIO-1:0]         data_out,
  output logic [$clog2(RATIO):0]        out_lanes,
  output logic                          output_valid,
  input  logic                          output_enable,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(RATIO) + 1;
  localparam int unsigned BW = $clog2(RATIO);
  localparam int unsigned WW = IN_W * RATIO;

  logic [WW-1:0] mem_data_q  [DEPTH];
  logic [LW-1:0] mem_lanes_q [DEPTH];

  logic [WW-1:0] pack_q,   pack_d;
  logic [BW-1:0] bcnt_q,   bcnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic          last_c;
  logic          accept_c;
  logic          pop_c;
  logic          commit_c;
  logic [WW-1:0] word_c;
  logic [LW-1:0] lanes_c;

  // Status flags and show-ahead head word, all derived from registered state.
  assign full         = (count_q == (AW+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign output_valid = !empty;
  assign last_c       = (bcnt_q == BW'(RATIO - 1));
  // A full FIFO still takes beats that only fill the packing register.
  assign input_enable = !full || !last_c;
  assign data_out     = mem_data_q[rd_ptr_q];
  assign out_lanes    = mem_lanes_q[rd_ptr_q];

  // Next-state: merge the incoming beat, decide commit/pop, move pointers.
  always_comb begin
    word_c   = pack_q;
    pack_d   = pack_q;
    bcnt_d   = bcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    accept_c = input_valid && input_enable;
    pop_c    = output_valid && output_enable;

    for (int unsigned i = 0; i < RATIO; i++) begin
      if (accept_c && (bcnt_q == BW'(i))) begin
        word_c[i*IN_W +: IN_W] = data_in;
      end
    end
    lanes_c = LW'(bcnt_q) + LW'(accept_c);

    // Flush covers a beat arriving this cycle; a full FIFO holds it off.
    commit_c = !full && ((accept_c && last_c) || (flush && (lanes_c != '0)));

    if (commit_c) begin
      pack_d   = '0;
      bcnt_d   = '0;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else if (accept_c) begin
      pack_d = word_c;
      bcnt_d = bcnt_q + BW'(1);
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    count_d = count_q + (AW+1)'(commit_c) - (AW+1)'(pop_c);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pack_q   <= '0;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pack_q   <= pack_d;
      bcnt_q   <= bcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never reset, output_valid hides stale words.
  always_ff @(posedge clk) begin
    if (rstn && commit_c) begin
      mem_data_q[wr_ptr_q]  <= word_c;
      mem_lanes_q[wr_ptr_q] <= lanes_c;
    end
  end

endmodule

// File: tb/tb_fifo_pack.sv
// Self-checking bench for fifo_pack (IN_W=8, RATIO=2, DEPTH=32): a queue-based
// reference model is compared every cycle, plus literal expectations.
module tb_fifo_pack;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned RATIO = 2;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned WW    = IN_W * RATIO;

  logic            clk;
  logic            rstn;
  logic [IN_W-1:0] data_in;
  logic            input_valid;
  logic            input_enable;
  logic            flush;
  logic [WW-1:0]   data_out;
  logic [1:0]      out_lanes;
  logic            output_valid;
  logic            output_enable;
  logic [5:0]      count;
  logic            full;
  logic            empty;

  int tests;
  int fails;

  fifo_pack #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .input_valid   (input_valid),
    .input_enable  (input_enable),
    .flush         (flush),
    .data_out      (data_out),
    .out_lanes     (out_lanes),
    .output_valid  (output_valid),
    .output_enable (output_enable),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored words and the beats of the word being packed.
  logic [WW-1:0]   mq_d [$];
  int unsigned     mq_l [$];
  logic [IN_W-1:0] part [$];

  always @(posedge clk) begin : model
    bit            mfull;
    bit            acc;
    bit            pop;
    logic [WW-1:0] w;
    if (!rstn) begin
      mq_d.delete();
      mq_l.delete();
      part.delete();
    end else begin
      mfull = (mq_d.size() == DEPTH);
      acc   = input_valid && (!mfull || (part.size() != RATIO - 1));
      pop   = (mq_d.size() != 0) && output_enable;
      if (pop) begin
        void'(mq_d.pop_front());
        void'(mq_l.pop_front());
      end
      if (acc) part.push_back(data_in);
      if (!mfull && ((part.size() == RATIO) || (flush && (part.size() != 0)))) begin
        w = '0;
        foreach (part[i]) w[i*IN_W +: IN_W] = part[i];
        mq_d.push_back(w);
        mq_l.push_back(part.size());
        part.delete();
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit exp_ie;
    exp_ie = (mq_d.size() != DEPTH) || (part.size() != RATIO - 1);
    check("m_input_enable", 64'(input_enable), 64'(exp_ie));
    check("m_count", 64'(count), 64'(mq_d.size()));
    check("m_full", 64'(full), 64'(mq_d.size() == DEPTH));
    check("m_empty", 64'(empty), 64'(mq_d.size() == 0));
    check("m_output_valid", 64'(output_valid), 64'(mq_d.size() != 0));
    check("m_count_bound", 64'(count <= DEPTH), 64'(1));
    if (mq_d.size() != 0) begin
      check("m_data_out", 64'(data_out), 64'(mq_d[0]));
      check("m_out_lanes", 64'(out_lanes), 64'(mq_l[0]));
    end
  endtask

  // Apply inputs for one cycle, let the edge consume them, then compare.
  task automatic drive(input bit iv, input logic [IN_W-1:0] d, input bit fl, input bit oe);
    input_valid   = iv;
    data_in       = d;
    flush         = fl;
    output_enable = oe;
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && !empty; n++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_empty", 64'(empty), 64'(1));
  endtask

  initial begin
    logic [IN_W-1:0] seq;
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rstn = 1'b1;
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_ovalid", 64'(output_valid), 64'(0));
    check("rst_ienable", 64'(input_enable), 64'(1));

    // Two beats form one full word.
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    check("w1_not_yet", 64'(output_valid), 64'(0));
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    check("w1_valid", 64'(output_valid), 64'(1));
    check("w1_data", 64'(data_out), 64'h2211);
    check("w1_lanes", 64'(out_lanes), 64'(2));
    check("w1_count", 64'(count), 64'(1));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("w1_popped", 64'(empty), 64'(1));

    // Flush of a single beat, then a normal word.
    drive(1'b1, 8'hAB, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_data", 64'(data_out), 64'h00AB);
    check("fl_lanes", 64'(out_lanes), 64'(1));
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    check("fl_count", 64'(count), 64'(2));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("fl_next_data", 64'(data_out), 64'h0201);
    check("fl_next_lanes", 64'(out_lanes), 64'(2));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    // Flush with nothing packed does nothing.
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_idle_empty", 64'(empty), 64'(1));
    // Flush together with a first beat commits a one-lane word.
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    check("fl_same_data", 64'(data_out), 64'h005A);
    check("fl_same_lanes", 64'(out_lanes), 64'(1));
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to full, accept one partial beat, then back-pressure.
    for (int i = 0; i < 64; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_flag", 64'(full), 64'(1));
    check("full_count", 64'(count), 64'(32));
    check("full_head", 64'(data_out), 64'h0100);
    check("full_ie_partial", 64'(input_enable), 64'(1));
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    check("full_ie_blocked", 64'(input_enable), 64'(0));
    check("full_count65", 64'(count), 64'(32));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("pop_count", 64'(count), 64'(31));
    check("pop_ie", 64'(input_enable), 64'(1));
    check("pop_head", 64'(data_out), 64'h0302);
    drive(1'b1, 8'h41, 1'b0, 0);
    check("b66_count", 64'(count), 64'(32));
    // Flush while full is held off; the beat is still packed.
    drive(1'b1, 8'h42, 1'b1, 1'b0);
    check("flfull_count", 64'(count), 64'(32));
    check("flfull_ie", 64'(input_enable), 64'(0));
    // Full with a pending partial: concurrent beat is refused, pop proceeds.
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    check("fp_count", 64'(count), 64'(31));
    check("fp_ie", 64'(input_enable), 64'(1));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("fp_flush_count", 64'(count), 64'(32));
    drain();

    // Reset discards stored words and the partial beat.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'(3));
    rstn = 1'b0;
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    rstn = 1'b1;
    check("rst2_empty", 64'(empty), 64'(1));
    check("rst2_count", 64'(count), 64'(0));
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    check("rst2_data", 64'(data_out), 64'h4433);
    check("rst2_lanes", 64'(out_lanes), 64'(2));
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    // Concurrent push/pop traffic across pointer wrap.
    seq = 8'h00;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(3, 0) != 0, seq,
            $urandom_range(15, 0) == 0,
            (c < 100) ? ($urandom_range(3, 0) == 0) : ($urandom_range(2, 0) != 0));
      seq = seq + 8'h01;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
